// File: rtl/alu_bist_driver.sv
// BIST driver for the registered ALU: LFSR-generated vectors go out, and the ALU responses
// are folded into a 32-bit MISR that is compared against a golden signature at the end.
module alu_bist_driver #(
   parameter int unsigned NUM_VECTORS  = 10000,
   parameter int unsigned ALU_LATENCY  = 4,
   parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
   parameter logic [31:0] EXPECTED_SIG = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [31:0] A_out,
   output logic [31:0] B_out,
   output logic [3:0]  Alu_Cntrl_out,
   output logic        Cin_out,
   input  logic [31:0] OUT_in,
   input  logic        Zero_in,
   input  logic        oVerflow_in,
   input  logic        Carry_in,
   input  logic        Negative_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] signature,
   output logic [2:0]  dbg_state
);

   localparam int VW = $clog2(NUM_VECTORS + 1);
   localparam int WW = $clog2(ALU_LATENCY + 1);
   localparam logic [VW-1:0] LAST_VEC  = VW'(NUM_VECTORS - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(ALU_LATENCY);
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? LFSR_POLY : 32'h0);
   endfunction

   // Shift ops only look at the low five bits of B.
   function automatic logic [31:0] mask_b(input logic [3:0] op, input logic [31:0] v);
      return (op inside {4'h8, 4'h9, 4'hA}) ? {27'b0, v[4:0]} : v;
   endfunction

   state_t        state_q, state_d;
   logic [31:0]   lfsr_q, lfsr_d;
   logic [31:0]   misr_q, misr_d;
   logic [VW-1:0] vec_cnt_q, vec_cnt_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [3:0]    cntrl_q, cntrl_d;
   logic          cin_q, cin_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;

   logic [31:0]   step1, step2, seed1, seed2, misr_next;
   logic [3:0]    op_next;

   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      misr_d     = misr_q;
      vec_cnt_d  = vec_cnt_q;
      wait_cnt_d = wait_cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      cntrl_d    = cntrl_q;
      cin_d      = cin_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;

      step1     = lfsr_step(lfsr_q);
      step2     = lfsr_step(step1);
      seed1     = lfsr_step(LFSR_SEED);
      seed2     = lfsr_step(seed1);
      op_next   = (cntrl_q == 4'd12) ? 4'd0 : cntrl_q + 4'd1;
      misr_next = {misr_q[30:0], 1'b0} ^ (misr_q[31] ? MISR_POLY : 32'h0) ^ OUT_in
                  ^ {28'b0, Negative_in, oVerflow_in, Carry_in, Zero_in};

      // The first vector is loaded on the accepting edge so ISSUE is cycle 1 of its window.
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_ISSUE;
               lfsr_d     = seed2;
               misr_d     = 32'h0;
               vec_cnt_d  = '0;
               wait_cnt_d = WW'(1);
               a_d        = seed1;
               b_d        = mask_b(4'd0, seed2);
               cntrl_d    = 4'd0;
               cin_d      = 1'b0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
            end
         end
         S_ISSUE, S_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_CAPTURE;
            end else begin
               state_d    = S_WAIT;
               wait_cnt_d = wait_cnt_q + WW'(1);
            end
         end
         S_CAPTURE: begin
            misr_d    = misr_next;
            vec_cnt_d = vec_cnt_q + VW'(1);
            if (vec_cnt_q == LAST_VEC) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (misr_next == EXPECTED_SIG);
            end else begin
               state_d    = S_ISSUE;
               lfsr_d     = step2;
               wait_cnt_d = WW'(1);
               a_d        = step1;
               b_d        = mask_b(op_next, step2);
               cntrl_d    = op_next;
               cin_d      = ~cin_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         lfsr_q     <= LFSR_SEED;
         misr_q     <= 32'h0;
         vec_cnt_q  <= '0;
         wait_cnt_q <= '0;
         a_q        <= 32'h0;
         b_q        <= 32'h0;
         cntrl_q    <= 4'h0;
         cin_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         misr_q     <= misr_d;
         vec_cnt_q  <= vec_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cntrl_q    <= cntrl_d;
         cin_q      <= cin_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   assign A_out         = a_q;
   assign B_out         = b_q;
   assign Alu_Cntrl_out = cntrl_q;
   assign Cin_out       = cin_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign signature     = misr_q;
   assign dbg_state     = state_q;

endmodule
